// File: rtl/uart_cmd_wrapper.sv
// Host command link endpoint: 8N1 UART receiver assembling 3-byte cmd/data frames,
// plus an independent 1-byte response transmitter. All timing derived from BAUD_DIV.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604,
    parameter int TMO_BITS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int CW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TMO_LIM = TMO_BITS * BAUD_DIV;
    localparam int TW      = $clog2(TMO_LIM + 1);

    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_LIM);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} frm_state_t;

    // ---------------- RX synchronizer and shifter ----------------
    logic            rx_ff1, rx_sync, rx_prev;
    rx_state_t       rx_st;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sr;
    logic            start_det, rx_tick, rx_byte_vld, rx_frm_err, rx_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_sync <= rx_ff1;
            rx_prev <= rx_sync;
        end
    end

    assign rx_idle     = (rx_st == R_IDLE);
    assign start_det   = rx_idle && rx_prev && !rx_sync;
    assign rx_tick     = (rx_cnt == BIT_END);
    assign rx_byte_vld = (rx_st == R_STOP) && rx_tick && rx_sync;
    assign rx_frm_err  = (rx_st == R_STOP) && rx_tick && !rx_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st  <= R_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sr  <= '0;
        end else begin
            case (rx_st)
                R_IDLE: begin
                    if (start_det) begin
                        rx_st  <= R_START;
                        rx_cnt <= '0;
                    end
                end
                R_START: begin
                    // Half-bit re-check rejects glitches and aligns later samples to bit centres.
                    if (rx_cnt == HALF_END) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_sr  <= {rx_sync, rx_sr[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_st <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (rx_tick) begin
                        rx_cnt <= '0;
                        rx_st  <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    // ---------------- Frame assembly ----------------
    frm_state_t    fst;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    cmd_shadow, hi_shadow;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fst        <= WAIT_CMD;
            tmo_cnt    <= '0;
            cmd_shadow <= '0;
            hi_shadow  <= '0;
            cmd        <= '0;
            data       <= '0;
            cmd_rdy    <= 1'b0;
        end else begin
            if (start_det || fst == WAIT_CMD)
                tmo_cnt <= '0;
            else if (rx_idle && !tmo_hit)
                tmo_cnt <= tmo_cnt + TW'(1);

            // Later assignments below (commit) take precedence over the acknowledge.
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;

            if (rx_frm_err) begin
                fst <= WAIT_CMD;
            end else if (rx_byte_vld) begin
                case (fst)
                    WAIT_CMD: begin
                        cmd_shadow <= rx_sr;
                        cmd_rdy    <= 1'b0;
                        fst        <= WAIT_HI;
                    end
                    WAIT_HI: begin
                        hi_shadow <= rx_sr;
                        fst       <= WAIT_LO;
                    end
                    WAIT_LO: begin
                        cmd     <= cmd_shadow;
                        data    <= {hi_shadow, rx_sr};
                        cmd_rdy <= 1'b1;
                        fst     <= WAIT_CMD;
                    end
                    default: fst <= WAIT_CMD;
                endcase
            end else if (fst != WAIT_CMD && tmo_hit) begin
                fst <= WAIT_CMD;
            end
        end
    end

    // ---------------- TX shifter ----------------
    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            TX        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sr     <= '1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            if (!tx_busy) begin
                if (send_resp) begin
                    tx_busy <= 1'b1;
                    TX      <= 1'b0;
                    tx_sr   <= {1'b1, resp};
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                end
            end else if (tx_cnt == BIT_END) begin
                tx_cnt <= '0;
                // tx_bit 9 is the stop bit currently on the line.
                if (tx_bit == 4'd9) begin
                    tx_busy   <= 1'b0;
                    TX        <= 1'b1;
                    resp_sent <= 1'b1;
                end else begin
                    TX     <= tx_sr[0];
                    tx_sr  <= {1'b1, tx_sr[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: host-side UART driver, response-byte decoder, directed
// frame table, multi-cycle corner sequences and randomized full-duplex traffic.
module tb_uart_cmd_wrapper;

    localparam int BD  = 16;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    int checks = 0;
    int failures = 0;
    int rdy_at = -1;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [7:0]  e_cmd;
        logic [15:0] e_data;
    } vec_t;
    vec_t tbl [5];

    uart_cmd_wrapper #(.BAUD_DIV(BD), .TMO_BITS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One 8N1 byte, BD cycles per bit; optional one-cycle clr pulse at cycle clr_at.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int clr_at, input bit rec);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int c = 0; c < 10 * BD; c++) begin
            @(negedge clk);
            if (rec && rdy_at < 0 && cmd_rdy) rdy_at = c;
            rx = f[c / BD];
            clr_cmd_rdy = (c == clr_at);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int gap, input int clr_at, input bit rec);
        idle(gap); send_byte(b0, 1'b1, -1, 1'b0);
        idle(gap); send_byte(b1, 1'b1, -1, 1'b0);
        idle(gap); send_byte(b2, 1'b1, clr_at, rec);
    endtask

    task automatic check_frame(input string name, input logic [7:0] ec, input logic [15:0] ed);
        chk({name, "_rdy"}, cmd_rdy, 1'b1);
        chk({name, "_cmd"}, cmd, ec);
        chk({name, "_data"}, data, ed);
        m_cmd = ec;
        m_data = ed;
    endtask

    task automatic pulse_clr(input string name);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk({name, "_clr_rdy"}, cmd_rdy, 1'b0);
        chk({name, "_clr_cmd_held"}, cmd, m_cmd);
        chk({name, "_clr_data_held"}, data, m_data);
    endtask

    // Requests a response and decodes TX as the host would (bit-centre sampling).
    task automatic check_resp(input string name, input logic [7:0] r, input int second_at);
        logic [9:0] bits;
        logic       tx1;
        int         n_sent, first_at;
        bits = '0; tx1 = 1'b1; n_sent = 0; first_at = -1;
        @(negedge clk);
        resp = r;
        send_resp = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) begin send_resp = 1'b0; tx1 = tx; end
            if (k == second_at) send_resp = 1'b1;
            if (k == second_at + 1) send_resp = 1'b0;
            if (k == 60) resp = ~r;
            if (k >= BD / 2 && k <= 9 * BD + BD / 2 && ((k - BD / 2) % BD) == 0)
                bits[(k - BD / 2) / BD] = tx;
            if (resp_sent) begin
                n_sent++;
                if (first_at < 0) first_at = k;
            end
        end
        chk({name, "_tx_low_next"}, tx1, 1'b0);
        chk({name, "_tx_frame"}, bits, {1'b1, r, 1'b0});
        chk({name, "_sent_count"}, n_sent, 1);
        chk({name, "_sent_at"}, first_at, 10 * BD + 1);
    endtask

    initial begin
        tbl[0] = '{8'h02, 8'hA5, 8'h5A, 8'h02, 16'hA55A};
        tbl[1] = '{8'h01, 8'hFF, 8'hFF, 8'h01, 16'hFFFF};
        tbl[2] = '{8'h03, 8'h00, 8'hFF, 8'h03, 16'h00FF};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000};
        tbl[4] = '{8'hFF, 8'h80, 8'h01, 8'hFF, 16'h8001};

        // Reset state
        idle(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_data", data, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_resp_sent", resp_sent, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Test 1: first frame, commit timing, acknowledge
        send_frame(tbl[0].b0, tbl[0].b1, tbl[0].b2, 0, -1, 1'b1);
        check_frame("t1", tbl[0].e_cmd, tbl[0].e_data);
        chk("t1_commit_in_stop_bit", (rdy_at >= 9 * BD && rdy_at < 10 * BD), 1'b1);
        pulse_clr("t1");

        // Test 2: response transmit
        check_resp("t2", 8'hA5, -1);

        // Directed frame table
        for (int i = 1; i < 5; i++) begin
            send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, i * 3, -1, 1'b0);
            check_frame($sformatf("tbl%0d", i), tbl[i].e_cmd, tbl[i].e_data);
        end

        // Test 3: inter-byte timeout discards a partial frame
        send_byte(8'h05, 1'b1, -1, 1'b0);
        send_byte(8'h12, 1'b1, -1, 1'b0);
        idle(TMO * BD + 40);
        chk("t3_partial_rdy", cmd_rdy, 1'b0);
        chk("t3_partial_cmd", cmd, m_cmd);
        chk("t3_partial_data", data, m_data);
        send_frame(8'h06, 8'h12, 8'h34, 0, -1, 1'b0);
        check_frame("t3", 8'h06, 16'h1234);

        // Test 4: false start glitch, then framing error on byte 2
        rx = 1'b0; idle(4); rx = 1'b1; idle(30);
        chk("t4_glitch_rdy", cmd_rdy, 1'b1);
        send_frame(8'h3C, 8'h0F, 8'h0F, 0, -1, 1'b0);
        check_frame("t4_after_glitch", 8'h3C, 16'h0F0F);
        send_byte(8'hAA, 1'b1, -1, 1'b0);
        send_byte(8'h55, 1'b0, -1, 1'b0);
        @(negedge clk); rx = 1'b1; idle(20);
        chk("t4_ferr_rdy", cmd_rdy, 1'b0);
        chk("t4_ferr_cmd", cmd, m_cmd);
        send_frame(8'h01, 8'hFF, 8'hFF, 0, -1, 1'b0);
        check_frame("t4", 8'h01, 16'hFFFF);

        // Test 5: acknowledge coincident with commit; second request while busy
        send_frame(8'h11, 8'h22, 8'h33, 0, rdy_at - 1, 1'b0);
        check_frame("t5_commit_wins", 8'h11, 16'h2233);
        idle(3);
        chk("t5_rdy_holds", cmd_rdy, 1'b1);
        pulse_clr("t5");
        check_resp("t5", 8'h5A, 40);

        // Randomized full-duplex traffic against the frame/response model
        for (int n = 0; n < 12; n++) begin
            logic [7:0] b0, b1, b2, r;
            int gap;
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); r = 8'($urandom);
            gap = $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0; idle($urandom_range(1, 5)); rx = 1'b1; idle(20);
            end
            fork
                send_frame(b0, b1, b2, gap, -1, 1'b0);
                check_resp($sformatf("rnd%0d", n), r, -1);
            join
            check_frame($sformatf("rnd%0d", n), b0, {b1, b2});
            if ($urandom_range(0, 1) == 1) pulse_clr($sformatf("rnd%0d", n));
        end

        // Test 6: reset mid-frame and mid-TX
        send_frame(8'h5C, 8'hBE, 8'hEF, 0, -1, 1'b0);
        check_frame("t6_pre", 8'h5C, 16'hBEEF);
        send_byte(8'h77, 1'b1, -1, 1'b0);
        resp = 8'h00; send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0;
        idle(40);
        rst_n = 1'b0;
        idle(2);
        chk("t6_rst_tx", tx, 1'b1);
        chk("t6_rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("t6_rst_cmd", cmd, 8'h00);
        chk("t6_rst_data", data, 16'h0000);
        rst_n = 1'b1;
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (resp_sent) stray++;
            end
            chk("t6_no_stale_resp_sent", stray, 0);
        end
        send_frame(8'h03, 8'h00, 8'hFF, 0, -1, 1'b0);
        check_frame("t6", 8'h03, 16'h00FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
